// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor with valid/ready
// handshakes. Flush-to-zero inputs, round-to-nearest-even, IEEE-style flags.
// Pipeline of work per state: ALIGN -> ADD -> NORM -> ROUND -> DONE.
module fp_addsub_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op,
  input  logic [EXP_W+FRAC_W:0]   operando_a,
  input  logic [EXP_W+FRAC_W:0]   operando_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   resultado,
  output logic [3:0]              flags
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int SIG = FRAC_W + 4;
  localparam logic [31:0] SAT = 32'(FRAC_W + 3);

  typedef logic [W-1:0]     word_t;
  typedef logic [EXP_W-1:0] efield_t;
  typedef logic [EXP_W:0]   exp_t;
  typedef logic [SIG-1:0]   sig_t;

  localparam efield_t E_ONES = '1;
  localparam word_t   QNAN   = {1'b0, E_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t state, state_next;

  word_t  a_r, b_r;
  logic   sign_r;
  exp_t   exp_r;
  sig_t   big_r, small_r;
  logic   eff_sub_r;
  logic [SIG:0] sum_r;
  sig_t   norm_r;
  logic   special_r;
  word_t  spec_res_r;
  logic [3:0] spec_flags_r;

  logic sa, sb;
  efield_t ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa = a_r[W-1];
  assign sb = b_r[W-1];
  assign ea = a_r[W-2:FRAC_W];
  assign eb = b_r[W-2:FRAC_W];
  assign fa = a_r[FRAC_W-1:0];
  assign fb = b_r[FRAC_W-1:0];
  assign a_nan  = (ea == E_ONES) && (fa != '0);
  assign b_nan  = (eb == E_ONES) && (fb != '0);
  assign a_inf  = (ea == E_ONES) && (fa == '0);
  assign b_inf  = (eb == E_ONES) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: fixed four-step walk from acceptance to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic        al_special, al_sign, al_eff_sub;
  word_t       al_res;
  logic [3:0]  al_flags;
  exp_t        al_exp;
  sig_t        al_big, al_small;
  efield_t     big_e, sm_e;
  logic [FRAC_W-1:0] big_f, sm_f;
  logic        big_s, sm_s;
  logic [31:0] diff, shamt;
  logic [2*SIG-1:0] wide;

  // Operand ordering, alignment shift with sticky, and special-value resolution.
  always_comb begin
    al_special = 1'b1;
    al_res     = '0;
    al_flags   = '0;
    if ({ea, fa} >= {eb, fb}) begin
      big_e = ea; big_f = fa; big_s = sa;
      sm_e  = eb; sm_f  = fb; sm_s  = sb;
    end else begin
      big_e = eb; big_f = fb; big_s = sb;
      sm_e  = ea; sm_f  = fa; sm_s  = sa;
    end
    diff  = 32'(big_e) - 32'(sm_e);
    shamt = (diff > SAT) ? SAT : diff;
    wide  = {1'b1, sm_f, 3'b000, {SIG{1'b0}}} >> shamt;
    al_small   = {wide[2*SIG-1:SIG+1], wide[SIG] | (|wide[SIG-1:0])};
    al_big     = {1'b1, big_f, 3'b000};
    al_exp     = {1'b0, big_e};
    al_sign    = big_s;
    al_eff_sub = big_s ^ sm_s;
    if (a_nan || b_nan) begin
      al_res   = QNAN;
      al_flags = {(a_nan && !fa[FRAC_W-1]) || (b_nan && !fb[FRAC_W-1]), 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      al_res   = QNAN;
      al_flags = 4'b1000;
    end else if (a_inf) begin
      al_res = a_r;
    end else if (b_inf) begin
      al_res = b_r;
    end else if (a_zero && b_zero) begin
      al_res = {sa & sb, {(W-1){1'b0}}};
    end else if (b_zero) begin
      al_res = a_r;
    end else if (a_zero) begin
      al_res = b_r;
    end else begin
      al_special = 1'b0;
    end
  end

  logic [SIG:0] add_sum;

  // Magnitude add or subtract; the larger operand is always the minuend.
  always_comb begin
    if (eff_sub_r) add_sum = {1'b0, big_r} - {1'b0, small_r};
    else           add_sum = {1'b0, big_r} + {1'b0, small_r};
  end

  logic [31:0] lz, lim;
  sig_t        nm_sig;
  exp_t        nm_exp;
  logic        nm_zero, nm_uflow;

  // Normalisation: carry shifts right, otherwise leading-zero left shift bounded at exp=1.
  always_comb begin
    nm_sig   = '0;
    nm_exp   = exp_r;
    nm_zero  = 1'b0;
    nm_uflow = 1'b0;
    lz       = 32'(SIG);
    for (int i = 0; i < SIG; i++) begin
      if (sum_r[i]) lz = 32'(SIG - 1 - i);
    end
    lim = 32'(exp_r) - 32'd1;
    if (sum_r[SIG]) begin
      nm_sig = {sum_r[SIG:2], sum_r[1] | sum_r[0]};
      nm_exp = exp_r + exp_t'(1);
    end else if (sum_r == '0) begin
      nm_zero = 1'b1;
    end else if (lz > lim) begin
      nm_uflow = 1'b1;
    end else begin
      nm_sig = sum_r[SIG-1:0] << lz;
      nm_exp = exp_r - exp_t'(lz);
    end
  end

  logic              rd_g, rd_r, rd_s, rd_inc;
  logic [FRAC_W+1:0] mant;
  exp_t              rexp;
  logic [FRAC_W-1:0] rfrac;
  word_t             rd_res;
  logic [3:0]        rd_flags;

  // Round-to-nearest-even, mantissa carry-out, and overflow to infinity.
  always_comb begin
    rd_g   = norm_r[2];
    rd_r   = norm_r[1];
    rd_s   = norm_r[0];
    rd_inc = rd_g & (rd_r | rd_s | norm_r[3]);
    mant   = {1'b0, norm_r[SIG-1:3]} + (FRAC_W+2)'(rd_inc);
    rexp   = exp_r;
    rfrac  = mant[FRAC_W-1:0];
    if (mant[FRAC_W+1]) begin
      rexp  = exp_r + exp_t'(1);
      rfrac = '0;
    end
    if (special_r) begin
      rd_res   = spec_res_r;
      rd_flags = spec_flags_r;
    end else if (rexp >= {1'b0, E_ONES}) begin
      rd_res   = {sign_r, E_ONES, {FRAC_W{1'b0}}};
      rd_flags = 4'b0101;
    end else begin
      rd_res   = {sign_r, rexp[EXP_W-1:0], rfrac};
      rd_flags = {3'b000, rd_g | rd_r | rd_s};
    end
  end

  // Datapath registers, each stage loaded in the state that owns it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_r          <= '0;
      b_r          <= '0;
      sign_r       <= 1'b0;
      exp_r        <= '0;
      big_r        <= '0;
      small_r      <= '0;
      eff_sub_r    <= 1'b0;
      sum_r        <= '0;
      norm_r       <= '0;
      special_r    <= 1'b0;
      spec_res_r   <= '0;
      spec_flags_r <= '0;
      resultado    <= '0;
      flags        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= operando_a;
            b_r <= {operando_b[W-1] ^ op, operando_b[W-2:0]};
          end
        end
        ALIGN: begin
          special_r    <= al_special;
          spec_res_r   <= al_res;
          spec_flags_r <= al_flags;
          sign_r       <= al_sign;
          exp_r        <= al_exp;
          big_r        <= al_big;
          small_r      <= al_small;
          eff_sub_r    <= al_eff_sub;
        end
        ADD: sum_r <= add_sum;
        NORM: begin
          norm_r <= nm_sig;
          exp_r  <= nm_exp;
          if (!special_r && nm_zero) begin
            special_r    <= 1'b1;
            spec_res_r   <= '0;
            spec_flags_r <= 4'b0000;
          end else if (!special_r && nm_uflow) begin
            special_r    <= 1'b1;
            spec_res_r   <= {sign_r, {(W-1){1'b0}}};
            spec_flags_r <= 4'b0010;
          end
        end
        ROUND: begin
          resultado <= rd_res;
          flags     <= rd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
